count_readout: RTL and testbench

// - Downstream of the coincidence detector. Snapshots the clock, per-channel and pair counters when an acquisition window completes.
// - Streams the snapshot as a framed word sequence over a valid/ready interface toward the host link (UART/FIFO).
// - Then requests a detector restart for the next window.

---
 rtl/count_readout_if.sv | 12 +
 rtl/count_readout.sv | 136 +++++++++++++
 tb/tb_count_readout.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_readout_if.sv
// Valid/ready word stream from count_readout toward the host link.
interface count_readout_if #(
  parameter int NBITS = 4
);
  logic [NBITS-1:0] Data_o;
  logic             Valid_o;
  logic             Ready_i;
  logic             Last_o;

  modport master (output Data_o, Valid_o, Last_o, input Ready_i);
  modport slave  (input Data_o, Valid_o, Last_o, output Ready_i);
endinterface

// File: rtl/count_readout.sv
// count_readout: snapshots detector counters when a window completes and streams them as one frame.
// Optional macro CHECKSUM_EN appends an XOR checksum word to each frame.
module count_readout #(
  parameter int NCHAN = 4,
  parameter int NBITS = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Enable_i,
  input  logic [NBITS-1:0] nCycles_i,
  input  logic [NBITS-1:0] Cnt_Clk,
  input  logic [NBITS-1:0] Cnt_chann [NCHAN-1:0],
  input  logic [NBITS-1:0] Cnt_pairs [NCHAN*(NCHAN-1)/2-1:0],
  count_readout_if.master  bus,
  output logic             Busy_o,
  output logic             Restart_o,
  output logic             Overrun_o
);
  localparam int NPAIRS = NCHAN*(NCHAN-1)/2;
  localparam int NDATA  = 1 + NCHAN + NPAIRS;
`ifdef CHECKSUM_EN
  localparam int NWORDS = NDATA + 1;
`else
  localparam int NWORDS = NDATA;
`endif
  localparam int IDXW = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
`ifdef CHECKSUM_EN
    CSUM    = 2'd2,
`endif
    RESTART = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                        done, done_q, trigger, hs, last_data;
  logic [IDXW-1:0]             idx_q;
  logic [NDATA-1:0][NBITS-1:0] snap_q, snap_d;
  logic [NBITS-1:0]            word;

  assign done      = Enable_i && (Cnt_Clk == nCycles_i);
  assign trigger   = done && !done_q;
  assign hs        = bus.Valid_o && bus.Ready_i;
  assign last_data = (idx_q == IDXW'(NDATA - 1));

  // Frame order: clock count, channel counts, pair counts
  assign snap_d[0] = Cnt_Clk;
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign snap_d[1+c] = Cnt_chann[c];
  end
  for (genvar p = 0; p < NPAIRS; p++) begin : g_pair
    assign snap_d[1+NCHAN+p] = Cnt_pairs[p];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      done_q    <= 1'b0;
      Overrun_o <= 1'b0;
      snap_q    <= '0;
      idx_q     <= '0;
    end else begin
      done_q <= done;
      if (trigger && state_q != IDLE) Overrun_o <= 1'b1;
      if (trigger && state_q == IDLE) begin
        snap_q <= snap_d;
        idx_q  <= '0;
      end else if (state_q == SEND && hs && !last_data) begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NDATA; i++)
      if (idx_q == IDXW'(i)) word = snap_q[i];
  end

`ifdef CHECKSUM_EN
  logic [NBITS-1:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < NDATA; i++) csum = csum ^ snap_q[i];
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = SEND;
`ifdef CHECKSUM_EN
      SEND:    if (hs && last_data) state_d = CSUM;
      CSUM:    if (hs) state_d = RESTART;
`else
      SEND:    if (hs && last_data) state_d = RESTART;
`endif
      RESTART: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once
  always_comb begin
    bus.Data_o  = '0;
    bus.Valid_o = 1'b0;
    bus.Last_o  = 1'b0;
    Restart_o   = 1'b0;
    Busy_o      = (state_q != IDLE);
    case (state_q)
      SEND: begin
        bus.Valid_o = 1'b1;
        bus.Data_o  = word;
`ifndef CHECKSUM_EN
        bus.Last_o  = last_data;
`endif
      end
`ifdef CHECKSUM_EN
      CSUM: begin
        bus.Valid_o = 1'b1;
        bus.Data_o  = csum;
        bus.Last_o  = 1'b1;
      end
`endif
      RESTART: Restart_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_count_readout.sv
// Directed bench for count_readout: framing, stalls, snapshot isolation, overrun and reset.
module tb_count_readout;
  localparam int NCHAN  = 4;
  localparam int NBITS  = 4;
  localparam int NPAIRS = 6;
`ifdef CHECKSUM_EN
  localparam int NW = 12;
`else
  localparam int NW = 11;
`endif

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Enable_i = 1'b0;
  logic [NBITS-1:0] nCycles_i = '0;
  logic [NBITS-1:0] Cnt_Clk = '0;
  logic [NBITS-1:0] Cnt_chann [NCHAN-1:0];
  logic [NBITS-1:0] Cnt_pairs [NPAIRS-1:0];
  logic             Busy_o, Restart_o, Overrun_o;
  logic [NBITS-1:0] exp_w [12];
  int checks = 0;
  int errors = 0;

  count_readout_if #(.NBITS(NBITS)) bus ();

  count_readout #(.NCHAN(NCHAN), .NBITS(NBITS)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Enable_i  (Enable_i),
    .nCycles_i (nCycles_i),
    .Cnt_Clk   (Cnt_Clk),
    .Cnt_chann (Cnt_chann),
    .Cnt_pairs (Cnt_pairs),
    .bus       (bus),
    .Busy_o    (Busy_o),
    .Restart_o (Restart_o),
    .Overrun_o (Overrun_o)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_counts();
    Cnt_Clk   = 4'd5;
    nCycles_i = 4'd5;
    Cnt_chann[0] = 4'd1; Cnt_chann[1] = 4'd2; Cnt_chann[2] = 4'd3; Cnt_chann[3] = 4'd4;
    Cnt_pairs[0] = 4'd0; Cnt_pairs[1] = 4'd1; Cnt_pairs[2] = 4'd0;
    Cnt_pairs[3] = 4'd2; Cnt_pairs[4] = 4'd0; Cnt_pairs[5] = 4'd1;
  endtask

  // Raises done for exactly one edge; on return the first word should be on the bus
  task automatic fire();
    load_counts();
    Enable_i = 1'b1;
    tick();
    Enable_i = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    bus.Ready_i = 1'b0;
    load_counts();
    tick(); tick();
    checks++; if (bus.Valid_o !== 1'b0 || bus.Last_o !== 1'b0) begin errors++;
      $display("FAIL reset valid/last: got %b/%b want 0/0", bus.Valid_o, bus.Last_o); end
    checks++; if (bus.Data_o !== 4'h0) begin errors++;
      $display("FAIL reset data: got %h want 0", bus.Data_o); end
    checks++; if (Busy_o !== 1'b0 || Restart_o !== 1'b0 || Overrun_o !== 1'b0) begin errors++;
      $display("FAIL reset busy/restart/overrun: got %b%b%b want 000", Busy_o, Restart_o, Overrun_o); end
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.Ready_i = 1'b1;
    fire();
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (bus.Valid_o !== 1'b1 || bus.Data_o !== exp_w[i] || bus.Last_o !== (i == NW-1)) begin errors++;
        $display("FAIL b2b word %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, bus.Valid_o, bus.Data_o, bus.Last_o, exp_w[i], (i == NW-1)); end
      tick();
    end
    checks++; if (Restart_o !== 1'b1 || bus.Valid_o !== 1'b0 || Busy_o !== 1'b1) begin errors++;
      $display("FAIL b2b restart: got r=%b v=%b b=%b want 1 0 1", Restart_o, bus.Valid_o, Busy_o); end
    tick();
    checks++; if (Restart_o !== 1'b0 || Busy_o !== 1'b0) begin errors++;
      $display("FAIL b2b idle: got r=%b b=%b want 0 0", Restart_o, Busy_o); end
  endtask

  task automatic test_stall();
    int n = 0;
    int k = 0;
    fire();
    while (n < NW && k < 100) begin
      bus.Ready_i = (k % 4 == 0) || (k % 4 == 3);
      checks++;
      if (bus.Valid_o !== 1'b1 || bus.Data_o !== exp_w[n] || bus.Last_o !== (n == NW-1)) begin errors++;
        $display("FAIL stall word %0d cyc %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 n, k, bus.Valid_o, bus.Data_o, bus.Last_o, exp_w[n], (n == NW-1)); end
      if (bus.Ready_i) n++;
      tick();
      k++;
    end
    checks++; if (n != NW || Restart_o !== 1'b1) begin errors++;
      $display("FAIL stall end: got words=%0d restart=%b want %0d 1", n, Restart_o, NW); end
    bus.Ready_i = 1'b1;
    tick();
  endtask

  task automatic test_isolation();
    bus.Ready_i = 1'b1;
    fire();
    Cnt_Clk = 4'hF; nCycles_i = 4'hF - 4'h1; Enable_i = 1'b1;
    for (int c = 0; c < NCHAN; c++) Cnt_chann[c] = 4'hF;
    for (int p = 0; p < NPAIRS; p++) Cnt_pairs[p] = 4'hF;
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (bus.Valid_o !== 1'b1 || bus.Data_o !== exp_w[i]) begin errors++;
        $display("FAIL isolation word %0d: got v=%b d=%h want v=1 d=%h", i, bus.Valid_o, bus.Data_o, exp_w[i]); end
      tick();
    end
    checks++; if (Restart_o !== 1'b1) begin errors++;
      $display("FAIL isolation restart: got %b want 1", Restart_o); end
    Enable_i = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    bus.Ready_i = 1'b1;
    fire();
    tick(); tick();
    load_counts();
    Enable_i = 1'b1;
    tick();
    Enable_i = 1'b0;
    checks++; if (Overrun_o !== 1'b1) begin errors++;
      $display("FAIL overrun set: got %b want 1", Overrun_o); end
    for (int i = 3; i < NW; i++) begin
      checks++;
      if (bus.Valid_o !== 1'b1 || bus.Data_o !== exp_w[i]) begin errors++;
        $display("FAIL overrun word %0d: got v=%b d=%h want v=1 d=%h", i, bus.Valid_o, bus.Data_o, exp_w[i]); end
      tick();
    end
    tick(); tick(); tick();
    checks++; if (bus.Valid_o !== 1'b0 || Busy_o !== 1'b0 || Overrun_o !== 1'b1) begin errors++;
      $display("FAIL overrun after: got v=%b b=%b ovr=%b want 0 0 1", bus.Valid_o, Busy_o, Overrun_o); end
  endtask

  task automatic test_done_held();
    int nvalid = 0;
    int nlast  = 0;
    Rst_n = 1'b0; tick(); Rst_n = 1'b1; tick();
    checks++; if (Overrun_o !== 1'b0) begin errors++;
      $display("FAIL overrun clear: got %b want 0", Overrun_o); end
    bus.Ready_i = 1'b1;
    load_counts();
    Enable_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.Valid_o === 1'b1) nvalid++;
      if (bus.Valid_o === 1'b1 && bus.Last_o === 1'b1) nlast++;
    end
    Enable_i = 1'b0;
    checks++; if (nvalid != NW || nlast != 1) begin errors++;
      $display("FAIL done held: got words=%0d lasts=%0d want %0d 1", nvalid, nlast, NW); end
    checks++; if (Overrun_o !== 1'b0) begin errors++;
      $display("FAIL done held overrun: got %b want 0", Overrun_o); end
    tick();
  endtask

  task automatic test_reset_midframe();
    bus.Ready_i = 1'b1;
    fire();
    tick(); tick(); tick(); tick();
    checks++; if (bus.Data_o !== exp_w[4]) begin errors++;
      $display("FAIL midframe word4: got %h want %h", bus.Data_o, exp_w[4]); end
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (bus.Valid_o !== 1'b0 || bus.Last_o !== 1'b0 || Busy_o !== 1'b0 || Restart_o !== 1'b0) begin errors++;
      $display("FAIL midframe reset: got v=%b l=%b b=%b r=%b want 0000", bus.Valid_o, bus.Last_o, Busy_o, Restart_o); end
    tick();
    Rst_n = 1'b1;
    tick();
    fire();
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (bus.Valid_o !== 1'b1 || bus.Data_o !== exp_w[i] || bus.Last_o !== (i == NW-1)) begin errors++;
        $display("FAIL refire word %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, bus.Valid_o, bus.Data_o, bus.Last_o, exp_w[i], (i == NW-1)); end
      tick();
    end
    checks++; if (Restart_o !== 1'b1) begin errors++;
      $display("FAIL refire restart: got %b want 1", Restart_o); end
    tick();
  endtask

  task automatic test_zero_window();
    bus.Ready_i = 1'b0;
    load_counts();
    Cnt_Clk = 4'd0; nCycles_i = 4'd0; Enable_i = 1'b1;
    tick();
    Enable_i = 1'b0;
    checks++; if (bus.Valid_o !== 1'b1 || bus.Data_o !== 4'h0 || Busy_o !== 1'b1) begin errors++;
      $display("FAIL zero window: got v=%b d=%h b=%b want 1 0 1", bus.Valid_o, bus.Data_o, Busy_o); end
    tick();
    checks++; if (bus.Valid_o !== 1'b1 || bus.Data_o !== 4'h0) begin errors++;
      $display("FAIL zero window hold: got v=%b d=%h want 1 0", bus.Valid_o, bus.Data_o); end
    bus.Ready_i = 1'b1;
    for (int i = 0; i < NW + 1; i++) tick();
    checks++; if (Busy_o !== 1'b0 || bus.Valid_o !== 1'b0) begin errors++;
      $display("FAIL zero window drain: got b=%b v=%b want 0 0", Busy_o, bus.Valid_o); end
  endtask

  initial begin
    logic [NBITS-1:0] x;
    exp_w[0] = 4'd5; exp_w[1] = 4'd1; exp_w[2] = 4'd2; exp_w[3] = 4'd3;
    exp_w[4] = 4'd4; exp_w[5] = 4'd0; exp_w[6] = 4'd1; exp_w[7] = 4'd0;
    exp_w[8] = 4'd2; exp_w[9] = 4'd0; exp_w[10] = 4'd1;
    x = '0;
    for (int i = 0; i < 11; i++) x = x ^ exp_w[i];
    exp_w[11] = x;
    bus.Ready_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_isolation();
    test_overrun();
    test_done_held();
    test_reset_midframe();
    test_zero_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
